// File: rtl/fight_pkg.sv
// Shared definitions for the fighting-game match controller: action codes,
// controller FSM states, round result codes and health constants.
package fight_pkg;

    typedef enum logic [2:0] {
        ACT_KICK   = 3'b000,
        ACT_PUNCH  = 3'b001,
        ACT_AWAIT  = 3'b010,
        ACT_JUMP   = 3'b011,
        ACT_LEFT1  = 3'b100,
        ACT_LEFT2  = 3'b101,
        ACT_RIGHT1 = 3'b110,
        ACT_RIGHT2 = 3'b111
    } action_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RST_PLAYERS,
        ST_COLLECT,
        ST_STROBE,
        ST_CHECK,
        ST_MATCH_OVER
    } state_t;

    typedef enum logic [1:0] {
        RW_NONE = 2'b00,
        RW_P1   = 2'b01,
        RW_P2   = 2'b10,
        RW_DRAW = 2'b11
    } round_winner_t;

    localparam logic [1:0] HEALTH_KO = 2'b00;
    localparam logic [1:0] WINS_MAX  = 2'b11;

    // Saturating increment for the 2-bit wins counters.
    function automatic logic [1:0] sat_inc2(input logic [1:0] v);
        return (v == WINS_MAX) ? v : v + 2'd1;
    endfunction

endpackage

// File: rtl/fight_action_latch.sv
// One player's action capture: the first valid of a turn is kept, later ones
// are ignored until cleared. A fill request loads await into an empty latch.
module fight_action_latch
    import fight_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_clear,
    input  logic       i_valid,
    input  logic [2:0] i_act,
    input  logic       i_fill_await,
    output logic [2:0] o_act,
    output logic       o_full,
    output logic       o_full_next
);

    logic [2:0] r_act;
    logic       r_full;

    // Capture the first valid action (or the await fill) of the turn.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_act  <= ACT_AWAIT;
            r_full <= 1'b0;
        end else if (i_clear) begin
            r_act  <= ACT_AWAIT;
            r_full <= 1'b0;
        end else if (!r_full) begin
            if (i_valid) begin
                r_act  <= i_act;
                r_full <= 1'b1;
            end else if (i_fill_await) begin
                r_act  <= ACT_AWAIT;
                r_full <= 1'b1;
            end
        end
    end

    assign o_act       = r_act;
    assign o_full      = r_full;
    // Full after this edge: lets the controller leave collection in the same
    // cycle that the second latch fills.
    assign o_full_next = r_full | i_valid | i_fill_await;

endmodule

// File: rtl/fight_match_ctrl.sv
// Turn and round sequencer for the two-player fighting datapath.
// Optional feature macro: FIGHT_TURN_TIMEOUT_EN (action collection timeout).
module fight_match_ctrl
    import fight_pkg::*;
#(
    parameter int unsigned TURN_CYCLES   = 16,
    parameter int unsigned ROUND_TURNS   = 30,
    parameter int unsigned ROUNDS_TO_WIN = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       valid1,
    input  logic       valid2,
    input  logic [2:0] act_in1,
    input  logic [2:0] act_in2,
    input  logic [1:0] health1,
    input  logic [1:0] health2,
    output logic [2:0] action1,
    output logic [2:0] action2,
    output logic       actionEnable,
    output logic       players_reset_n,
    output logic       isGameOver,
    output logic [1:0] round_winner,
    output logic [1:0] wins1,
    output logic [1:0] wins2,
    output logic [7:0] turns_left
);

    // Elaboration-time parameter range guards.
    if (TURN_CYCLES < 1 || TURN_CYCLES > 255) begin : g_bad_turn_cycles
        $error("fight_match_ctrl: TURN_CYCLES out of range 1..255");
    end
    if (ROUND_TURNS < 1 || ROUND_TURNS > 255) begin : g_bad_round_turns
        $error("fight_match_ctrl: ROUND_TURNS out of range 1..255");
    end
    if (ROUNDS_TO_WIN < 1 || ROUNDS_TO_WIN > 3) begin : g_bad_rounds_to_win
        $error("fight_match_ctrl: ROUNDS_TO_WIN out of range 1..3");
    end

    state_t        r_state;
    logic          r_rst_cnt;
    logic          r_action_en;
    logic          r_prst_n;
    logic          r_game_over;
    round_winner_t r_round_winner;
    logic [1:0]    r_wins1;
    logic [1:0]    r_wins2;
    logic [7:0]    r_turns_left;

    logic          w_in_collect;
    logic          w_clear;
    logic          w_valid1;
    logic          w_valid2;
    logic          w_fill_await;
    logic          w_full1;
    logic          w_full2;
    logic          w_full1_next;
    logic          w_full2_next;
    logic          w_both_full;
    logic [7:0]    w_turns_dec;
    round_winner_t w_result;
    logic [1:0]    w_wins1_next;
    logic [1:0]    w_wins2_next;
    logic          w_match_end;

    assign w_in_collect = (r_state == ST_COLLECT);
    // Latches are emptied while players reset and on the way out of CHECK,
    // so every turn starts with both latches empty.
    assign w_clear      = (r_state == ST_RST_PLAYERS) || (r_state == ST_CHECK);
    assign w_valid1     = valid1 & w_in_collect;
    assign w_valid2     = valid2 & w_in_collect;
    assign w_both_full  = w_full1_next & w_full2_next;

`ifdef FIGHT_TURN_TIMEOUT_EN
    logic [7:0] r_timer;
    assign w_fill_await = w_in_collect && (r_timer == 8'(TURN_CYCLES - 1));
`else
    assign w_fill_await = 1'b0;
`endif

    fight_action_latch u_latch1 (
        .clk         (clk),
        .reset       (reset),
        .i_clear     (w_clear),
        .i_valid     (w_valid1),
        .i_act       (act_in1),
        .i_fill_await(w_fill_await),
        .o_act       (action1),
        .o_full      (w_full1),
        .o_full_next (w_full1_next)
    );

    fight_action_latch u_latch2 (
        .clk         (clk),
        .reset       (reset),
        .i_clear     (w_clear),
        .i_valid     (w_valid2),
        .i_act       (act_in2),
        .i_fill_await(w_fill_await),
        .o_act       (action2),
        .o_full      (w_full2),
        .o_full_next (w_full2_next)
    );

    // Round judgement from the sampled healths and the post-decrement turn count.
    always_comb begin
        w_turns_dec = (r_turns_left != 8'd0) ? r_turns_left - 8'd1 : 8'd0;
        w_result    = RW_NONE;
        if (health1 == HEALTH_KO && health2 == HEALTH_KO) begin
            w_result = RW_DRAW;
        end else if (health1 == HEALTH_KO) begin
            w_result = RW_P2;
        end else if (health2 == HEALTH_KO) begin
            w_result = RW_P1;
        end else if (w_turns_dec == 8'd0) begin
            if (health1 > health2)      w_result = RW_P1;
            else if (health2 > health1) w_result = RW_P2;
            else                        w_result = RW_DRAW;
        end
        w_wins1_next = (w_result == RW_P1) ? sat_inc2(r_wins1) : r_wins1;
        w_wins2_next = (w_result == RW_P2) ? sat_inc2(r_wins2) : r_wins2;
        w_match_end  = (w_wins1_next == 2'(ROUNDS_TO_WIN)) ||
                       (w_wins2_next == 2'(ROUNDS_TO_WIN));
    end

    // Match sequencer with registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= ST_IDLE;
            r_rst_cnt      <= 1'b0;
            r_action_en    <= 1'b0;
            r_prst_n       <= 1'b0;
            r_game_over    <= 1'b1;
            r_round_winner <= RW_NONE;
            r_wins1        <= 2'd0;
            r_wins2        <= 2'd0;
            r_turns_left   <= 8'(ROUND_TURNS);
`ifdef FIGHT_TURN_TIMEOUT_EN
            r_timer        <= '0;
`endif
        end else begin
            r_action_en <= 1'b0;
            case (r_state)
                ST_IDLE, ST_MATCH_OVER: begin
                    if (start) begin
                        r_wins1        <= 2'd0;
                        r_wins2        <= 2'd0;
                        r_round_winner <= RW_NONE;
                        r_rst_cnt      <= 1'b0;
                        r_prst_n       <= 1'b0;
                        r_game_over    <= 1'b1;
                        r_state        <= ST_RST_PLAYERS;
                    end
                end
                ST_RST_PLAYERS: begin
                    r_turns_left <= 8'(ROUND_TURNS);
                    if (r_rst_cnt) begin
                        r_prst_n    <= 1'b1;
                        r_game_over <= 1'b0;
                        r_state     <= ST_COLLECT;
`ifdef FIGHT_TURN_TIMEOUT_EN
                        r_timer     <= '0;
`endif
                    end else begin
                        r_rst_cnt <= 1'b1;
                    end
                end
                ST_COLLECT: begin
`ifdef FIGHT_TURN_TIMEOUT_EN
                    r_timer <= r_timer + 8'd1;
`endif
                    if (w_both_full) begin
                        r_action_en <= 1'b1;
                        r_state     <= ST_STROBE;
                    end
                end
                ST_STROBE: begin
                    r_state <= ST_CHECK;
                end
                ST_CHECK: begin
                    r_turns_left <= w_turns_dec;
                    if (w_result == RW_NONE) begin
                        r_state <= ST_COLLECT;
`ifdef FIGHT_TURN_TIMEOUT_EN
                        r_timer <= '0;
`endif
                    end else begin
                        r_round_winner <= w_result;
                        r_wins1        <= w_wins1_next;
                        r_wins2        <= w_wins2_next;
                        if (w_result != RW_DRAW && w_match_end) begin
                            r_prst_n    <= 1'b1;
                            r_game_over <= 1'b1;
                            r_state     <= ST_MATCH_OVER;
                        end else begin
                            r_rst_cnt   <= 1'b0;
                            r_prst_n    <= 1'b0;
                            r_game_over <= 1'b1;
                            r_state     <= ST_RST_PLAYERS;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign actionEnable    = r_action_en;
    assign players_reset_n = r_prst_n;
    assign isGameOver      = r_game_over;
    assign round_winner    = r_round_winner;
    assign wins1           = r_wins1;
    assign wins2           = r_wins2;
    assign turns_left      = r_turns_left;

endmodule

// File: doc/fight_match_ctrl.md
# fight_match_ctrl

Turn and round sequencer for the two-player fighting datapath. Collects one action per player per turn, presents both together with a single-cycle `actionEnable` strobe, and reads back both health values after the turn. Detects knockouts and turn-limit expiry, resets the player FSMs between rounds, keeps the match score, and drives `isGameOver`. Sits between the button front-end and the two player-state modules.

## Interface
- `TURN_CYCLES`, default 16: timeout in cycles for action collection (used only with `FIGHT_TURN_TIMEOUT_EN`); range 1–255.
- `ROUND_TURNS`, default 30: turns per round before time-out judgement; range 1–255.
- `ROUNDS_TO_WIN`, default 2: round wins that end the match; range 1–3.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-low.
- `start`  in  1  one-cycle pulse; begins a match from IDLE or MATCH_OVER.
- `valid1` / `valid2`  in  1  the action input for that player is presented this cycle.
- `act_in1` / `act_in2`  in  3  requested action (kick 000, punch 001, await 010, jump 011, left1 100, left2 101, right1 110, right2 111).
- `health1` / `health2`  in  2  current player health; 0 means KO.
- `action1` / `action2`  out  3  latched actions to the player modules.
- `actionEnable`  out  1  turn strobe, high for exactly one cycle.
- `players_reset_n`  out  1  active-low reset to both player modules.
- `isGameOver`  out  1  freezes the player modules.
- `round_winner`  out  2  result of the last round: 00 none, 01 P1, 10 P2, 11 draw.
- `wins1` / `wins2`  out  2  rounds won in the current match.
- `turns_left`  out  8  turns remaining in the current round.

## Operation
- FSM states: IDLE, RST_PLAYERS, COLLECT, STROBE, CHECK, MATCH_OVER.
- **Reset values:**
  - state: IDLE.
  - `action1`/`action2`: 010 (await).
  - `actionEnable`: 0.
  - `players_reset_n`: 0.
  - `isGameOver`: 1.
  - `round_winner`: 00.
  - `wins1`/`wins2`: 0.
  - `turns_left`: `ROUND_TURNS`.
- **IDLE.** `start` clears the wins and `round_winner`, then goes to RST_PLAYERS.
- **RST_PLAYERS** (2 cycles):
  - `players_reset_n` = 0 and `isGameOver` = 1.
  - `turns_left` is loaded with `ROUND_TURNS`.
  - Both action latches are cleared.
  - Next state is COLLECT.
- **COLLECT:**
  - For each player, the first cycle with `validN` = 1 latches `act_inN`. Later valids in the same turn are ignored.
  - The FSM leaves COLLECT in the cycle in which both latches are full. A valid that fills the second latch counts in that same cycle.
- **STROBE** (1 cycle): `actionEnable` = 1 and `action1`/`action2` are stable.
- **CHECK** (1 cycle): samples `health1`/`health2` and decrements `turns_left`. Outcomes:
  - Both healths 0: draw. `round_winner` = 11, no wins change, go to RST_PLAYERS (the round is replayed).
  - Exactly one health is 0: the other player wins the round. `round_winner` is set and that player's wins counter increments.
  - Otherwise, if `turns_left` reaches 0: the player with the higher health wins; equal health is a draw.
  - Otherwise: clear the latches and return to COLLECT.
- **After a round win:**
  - If either wins counter equals `ROUNDS_TO_WIN`, go to MATCH_OVER.
  - Otherwise go to RST_PLAYERS.
- **MATCH_OVER:**
  - `isGameOver` = 1; `players_reset_n` = 1, so final health stays visible.
  - `round_winner` and the wins counters hold.
  - `start` behaves as it does in IDLE.
- **`isGameOver` value by state:** 0 in COLLECT, STROBE and CHECK; 1 in every other state.
- **Widths:**
  - Wins counters saturate at 3.
  - Health compares are unsigned 2-bit.
  - Health wrap-around inside the player modules is not detected; only 0 counts as a KO.
- **`start` outside IDLE/MATCH_OVER:** ignored.

## Timing
- Minimum turn length is 3 cycles (COLLECT with both valids in one cycle, then STROBE, then CHECK).
- `actionEnable` rises on the clock edge after both latches are full and falls one cycle later. It is never high two cycles in a row, which guarantees the player modules see the required low phase.
- Health is sampled in CHECK, one cycle after the STROBE edge.
- Latency from the last valid to `round_winner` updating is 3 edges.
- Reset asserted mid-turn: all outputs return to their reset values immediately (asynchronous); `players_reset_n` goes low in the same instant.

## Configuration
- Macro: `FIGHT_TURN_TIMEOUT_EN`.
- **Defined:**
  - A collection timer counts COLLECT cycles.
  - After `TURN_CYCLES` cycles, any unfilled latch is loaded with await (010) and the FSM proceeds to STROBE.
  - The timer restarts on every entry to COLLECT.
- **Undefined:** COLLECT waits indefinitely for both valids, and `TURN_CYCLES` is unused.

## Structure
- Shared package `fight_pkg` holds:
  - the action encodings;
  - the FSM state enum;
  - the `round_winner` codes (NONE, P1, P2, DRAW);
  - `HEALTH_KO` = 2'b00.
- Sub-module `fight_action_latch` handles one player's first-valid capture. It provides a full flag, an await default, and a clear input, and is instantiated twice.

## Test plan
- **Normal turn.** `start`, wait 2 reset cycles, then `valid1` with kick and `valid2` with await in the same cycle. Expect `actionEnable` high exactly 1 cycle, 1 edge later, with `action1` = 000 and `action2` = 010. `turns_left` goes 30 → 29.
- **First valid wins.** P1 presents punch, then kick one cycle later; P2 presents left1. Expect `action1` = 001.
- **Simultaneous KO.** Force `health1` = `health2` = 0 at CHECK. Expect `round_winner` = 11, wins unchanged, and `players_reset_n` low for 2 cycles.
- **Match end.** P2 KOs P1 in two rounds. Expect `wins2` = 2, MATCH_OVER, `isGameOver` = 1, and all later valids ignored. A following `start` clears the wins.
- **Turn limit.** `ROUND_TURNS` = 2; after the final turn `health1` = 3 and `health2` = 1. Expect `round_winner` = 01 and `wins1` = 1.
- **Timeout** (with `FIGHT_TURN_TIMEOUT_EN`). Only P1 presents a valid. After 16 cycles expect the strobe with `action2` = 010. Asserting reset during STROBE drops `actionEnable` immediately.
